sram_bus_arbiter: RTL and testbench

Shares one SRAM-like bus (req / addr_ok / data_ok handshake) between the instruction-fetch port (IF) and the data port (MEM).
Sequences one outstanding transaction at a time.
Generates stallreq_from_if and stallreq_from_mem for the hazard unit.
Holds each completed response until the pipeline advances, so a fetch finished during a MEM stall is not re-issued.

---
 rtl/sram_bus_arbiter_pkg.sv | 17 +
 rtl/sram_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: FSM states, owner codes, and bus size codes.
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the IF and MEM ports, one transaction at a time.
// Build option ARB_ROUND_ROBIN_EN: alternate grants on contested arbitration instead of fixed data priority.
//
// state   | meaning
// IDLE    | no transaction outstanding, arbitrate pending ports
// ADDR    | bus_req_o high, waiting for addr_ok
// DATA    | address accepted, waiting for data_ok
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              stallreq_from_if,
  input  logic              data_req_i,
  input  logic              data_wr_i,
  input  logic [1:0]        data_size_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              stallreq_from_mem,
  input  logic              pipe_stall_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [1:0]        bus_size_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_addr_ok_i,
  input  logic              bus_data_ok_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  state_t state_q, state_d;
  logic   owner_q, cancel_q, inst_done_q, data_done_q;
  logic   inst_pend, data_pend, grant, grant_data, resp_ok, resp_valid, advance;
`ifdef ARB_ROUND_ROBIN_EN
  logic   last_owner_q;
`endif

  assign inst_pend         = inst_req_i & ~inst_done_q;
  assign data_pend         = data_req_i & ~data_done_q;
  assign stallreq_from_if  = inst_pend;
  assign stallreq_from_mem = data_pend;
  assign advance           = ~pipe_stall_i | flush_i;
  // A flush landing on the data_ok cycle still belongs to the squashed instruction.
  assign resp_valid        = resp_ok & ~cancel_q & ~flush_i;

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_data = 1'b0;
    resp_ok    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (inst_pend | data_pend) begin
          grant   = 1'b1;
          state_d = ST_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          grant_data = data_pend & (~inst_pend | (last_owner_q == OWN_INST));
`else
          grant_data = data_pend;
`endif
        end
      end
      ST_ADDR: if (bus_addr_ok_i) state_d = ST_DATA;
      ST_DATA: begin
        if (bus_data_ok_i) begin
          resp_ok = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      cancel_q     <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_o <= '0;
      data_rdata_o <= '0;
      bus_req_o    <= 1'b0;
      bus_wr_o     <= 1'b0;
      bus_size_o   <= '0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_INST;
`endif
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q     <= grant_data ? OWN_DATA : OWN_INST;
        bus_req_o   <= 1'b1;
        bus_wr_o    <= grant_data & data_wr_i;
        bus_size_o  <= grant_data ? data_size_i : SZ_WORD;
        bus_addr_o  <= grant_data ? data_addr_i : inst_addr_i;
        bus_wdata_o <= grant_data ? data_wdata_i : '0;
      end else if (state_q == ST_ADDR && bus_addr_ok_i) begin
        bus_req_o <= 1'b0;
      end
`ifdef ARB_ROUND_ROBIN_EN
      // Only contested grants move the round-robin pointer.
      if (grant && inst_pend && data_pend) last_owner_q <= grant_data ? OWN_DATA : OWN_INST;
`endif
      if (resp_ok) cancel_q <= 1'b0;
      else if (flush_i && (grant || state_q != ST_IDLE)) cancel_q <= 1'b1;

      if (resp_valid && owner_q == OWN_INST) begin
        inst_done_q  <= 1'b1;
        inst_rdata_o <= bus_rdata_i;
      end else if (advance) begin
        inst_done_q <= 1'b0;
      end

      // Bus fields stay put after addr_ok, so bus_wr_o still tags the finishing access.
      if (resp_valid && owner_q == OWN_DATA) begin
        data_done_q <= 1'b1;
        if (!bus_wr_o) data_rdata_o <= bus_rdata_i;
      end else if (advance) begin
        data_done_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: scripted bus slave with an expected-transaction scoreboard.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_req_i = 1'b0, data_req_i = 1'b0, data_wr_i = 1'b0;
  logic [31:0] inst_addr_i = '0, data_addr_i = '0, data_wdata_i = '0;
  logic [1:0]  data_size_i = '0;
  logic        pipe_stall_i = 1'b0, flush_i = 1'b0;
  logic        bus_addr_ok_i = 1'b0, bus_data_ok_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic [31:0] inst_rdata_o, data_rdata_o, bus_addr_o, bus_wdata_o;
  logic        stallreq_from_if, stallreq_from_mem, bus_req_o, bus_wr_o;
  logic [1:0]  bus_size_o;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_rdata_o(inst_rdata_o),
    .stallreq_from_if(stallreq_from_if),
    .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_size_i(data_size_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .stallreq_from_mem(stallreq_from_mem),
    .pipe_stall_i(pipe_stall_i), .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_size_o(bus_size_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_addr_ok_i(bus_addr_ok_i), .bus_data_ok_i(bus_data_ok_i), .bus_rdata_i(bus_rdata_i)
  );

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    txn_t t;
    int   a_dly;
    int   d_dly;
  } vec_t;

  int   total = 0, bad = 0;
  txn_t exp_q[$];
  txn_t cur;
  int   addr_dly = 0, data_dly = 0;
  int   hs_cnt = 0, inst_hs = 0, dok_cnt = 0;
  int   s_phase = 0, s_cnt = 0;
  logic [31:0] mdl_inst = '0, mdl_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bus slave + scoreboard: compares presented fields with the head entry, then answers.
  always @(negedge clk) begin
    bus_addr_ok_i = 1'b0;
    bus_data_ok_i = 1'b0;
    bus_rdata_i   = '0;
    if (rst) begin
      s_phase = 0;
      s_cnt   = 0;
    end else if (s_phase == 0) begin
      if (bus_req_o) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: bus request addr %h, expected none", bus_addr_o);
        end else begin
          chk("bus_addr", bus_addr_o, exp_q[0].addr);
          chk("bus_wr", 32'(bus_wr_o), 32'(exp_q[0].wr));
          chk("bus_size", 32'(bus_size_o), 32'(exp_q[0].size));
          if (exp_q[0].wr) chk("bus_wdata", bus_wdata_o, exp_q[0].wdata);
          if (s_cnt >= addr_dly) begin
            bus_addr_ok_i = 1'b1;
            cur     = exp_q.pop_front();
            s_phase = 1;
            s_cnt   = 0;
            hs_cnt++;
            if (bus_addr_o[31:28] == 4'hB) inst_hs++;
          end else begin
            s_cnt++;
          end
        end
      end
    end else begin
      if (s_cnt >= data_dly) begin
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = cur.rdata;
        s_phase       = 0;
        s_cnt         = 0;
        dok_cnt++;
      end else begin
        s_cnt++;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int limit, output int n);
    n = 0;
    #1;
    while ((stallreq_from_if || stallreq_from_mem) && n < limit) begin
      cyc();
      n++;
    end
    chk({name, "_done_in_time"}, 32'(n < limit), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   n, b0, h0, d0;
    vt[0] = '{t: '{1'b0, 1'b0, SZ_WORD, 32'hBFC00000, 32'h0, 32'h3C080001}, a_dly: 0, d_dly: 0};
    vt[1] = '{t: '{1'b1, 1'b0, SZ_WORD, 32'h80001000, 32'h0, 32'h11223344}, a_dly: 1, d_dly: 2};
    vt[2] = '{t: '{1'b1, 1'b1, SZ_BYTE, 32'h80000003, 32'h000000AA, 32'hFFFFFFFF}, a_dly: 2, d_dly: 0};
    vt[3] = '{t: '{1'b1, 1'b0, SZ_HALF, 32'h80000012, 32'h0, 32'h0000BEEF}, a_dly: 0, d_dly: 1};
    vt[4] = '{t: '{1'b0, 1'b0, SZ_WORD, 32'hBFC00008, 32'h0, 32'h24020005}, a_dly: 3, d_dly: 3};

    // reset state
    cyc(); cyc();
    chk("rst_bus_req", 32'(bus_req_o), 0);
    chk("rst_bus_wr", 32'(bus_wr_o), 0);
    chk("rst_bus_size", 32'(bus_size_o), 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_inst_rdata", inst_rdata_o, 0);
    chk("rst_data_rdata", data_rdata_o, 0);
    chk("rst_stall_if", 32'(stallreq_from_if), 0);
    chk("rst_stall_mem", 32'(stallreq_from_mem), 0);
    rst = 1'b0;
    cyc();

    // single-port transactions
    for (int i = 0; i < 5; i++) begin
      addr_dly = vt[i].a_dly;
      data_dly = vt[i].d_dly;
      exp_q.push_back(vt[i].t);
      pipe_stall_i = 1'b1;
      if (vt[i].t.is_data) begin
        data_req_i   = 1'b1;
        data_wr_i    = vt[i].t.wr;
        data_size_i  = vt[i].t.size;
        data_addr_i  = vt[i].t.addr;
        data_wdata_i = vt[i].t.wdata;
      end else begin
        inst_req_i  = 1'b1;
        inst_addr_i = vt[i].t.addr;
      end
      wait_idle("vec", 40, n);
      chk("vec_latency", n, 3 + vt[i].a_dly + vt[i].d_dly);
      if (!vt[i].t.is_data) begin
        chk("vec_inst_rdata", inst_rdata_o, vt[i].t.rdata);
        mdl_inst = vt[i].t.rdata;
      end else if (vt[i].t.wr) begin
        chk("vec_store_rdata_kept", data_rdata_o, mdl_data);
      end else begin
        chk("vec_load_rdata", data_rdata_o, vt[i].t.rdata);
        mdl_data = vt[i].t.rdata;
      end
      inst_req_i = 1'b0; data_req_i = 1'b0; data_wr_i = 1'b0; pipe_stall_i = 1'b0;
      cyc();
    end
    addr_dly = 0; data_dly = 0;

    // simultaneous requests, two ties in a row
    exp_q.push_back('{1'b1, 1'b0, SZ_WORD, 32'h80001000, 32'h0, 32'hA5A5A5A5});
    exp_q.push_back('{1'b0, 1'b0, SZ_WORD, 32'hBFC00004, 32'h0, 32'h8C010000});
    pipe_stall_i = 1'b1;
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC00004;
    data_req_i = 1'b1; data_wr_i = 1'b0; data_size_i = SZ_WORD; data_addr_i = 32'h80001000;
    wait_idle("tie1", 40, n);
    chk("tie1_data_rdata", data_rdata_o, 32'hA5A5A5A5);
    chk("tie1_inst_rdata", inst_rdata_o, 32'h8C010000);
    pipe_stall_i = 1'b0;
    inst_addr_i = 32'hBFC00008; data_addr_i = 32'h80001004;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back('{1'b0, 1'b0, SZ_WORD, 32'hBFC00008, 32'h0, 32'h00000001});
    exp_q.push_back('{1'b1, 1'b0, SZ_WORD, 32'h80001004, 32'h0, 32'h00000002});
`else
    exp_q.push_back('{1'b1, 1'b0, SZ_WORD, 32'h80001004, 32'h0, 32'h00000002});
    exp_q.push_back('{1'b0, 1'b0, SZ_WORD, 32'hBFC00008, 32'h0, 32'h00000001});
`endif
    cyc();
    pipe_stall_i = 1'b1;
    wait_idle("tie2", 40, n);
    chk("tie2_inst_rdata", inst_rdata_o, 32'h00000001);
    chk("tie2_data_rdata", data_rdata_o, 32'h00000002);
    inst_req_i = 1'b0; data_req_i = 1'b0; pipe_stall_i = 1'b0;
    cyc();

    // fetch result held across a MEM stall
    b0 = inst_hs;
    exp_q.push_back('{1'b0, 1'b0, SZ_WORD, 32'hBFC00010, 32'h0, 32'h11111111});
    pipe_stall_i = 1'b1;
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC00010;
    wait_idle("held_fetch", 40, n);
    chk("held_inst_rdata", inst_rdata_o, 32'h11111111);
    addr_dly = 20;
    exp_q.push_back('{1'b1, 1'b0, SZ_WORD, 32'h80002000, 32'h0, 32'h55AA55AA});
    data_req_i = 1'b1; data_wr_i = 1'b0; data_size_i = SZ_WORD; data_addr_i = 32'h80002000;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("held_if_stall", 32'(stallreq_from_if), 0);
      chk("held_mem_stall", 32'(stallreq_from_mem), 1);
    end
    chk("held_one_fetch", inst_hs - b0, 1);
    pipe_stall_i = 1'b0;
    inst_addr_i = 32'hBFC00014;
    exp_q.push_back('{1'b0, 1'b0, SZ_WORD, 32'hBFC00014, 32'h0, 32'h22222222});
    cyc();
    pipe_stall_i = 1'b1;
    #1;
    chk("held_release", 32'(stallreq_from_if), 1);
    addr_dly = 0;
    wait_idle("held_rest", 60, n);
    chk("held_data_rdata", data_rdata_o, 32'h55AA55AA);
    chk("held_inst_rdata2", inst_rdata_o, 32'h22222222);
    mdl_inst = 32'h22222222;
    inst_req_i = 1'b0; data_req_i = 1'b0; pipe_stall_i = 1'b0;
    cyc();

    // flush while the fetch sits in DATA
    data_dly = 3;
    exp_q.push_back('{1'b0, 1'b0, SZ_WORD, 32'hBFC00020, 32'h0, 32'hDEADBEEF});
    pipe_stall_i = 1'b1;
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC00020;
    h0 = hs_cnt;
    n = 0;
    while (hs_cnt == h0 && n < 20) begin cyc(); n++; end
    chk("flush_addr_phase_in_time", 32'(n < 20), 1);
    cyc();
    flush_i = 1'b1;
    inst_addr_i = 32'hBFC00380;
    exp_q.push_back('{1'b0, 1'b0, SZ_WORD, 32'hBFC00380, 32'h0, 32'h3C1A8000});
    d0 = dok_cnt;
    cyc();
    flush_i = 1'b0;
    n = 0;
    while (dok_cnt == d0 && n < 20) begin cyc(); n++; end
    chk("flush_data_phase_in_time", 32'(n < 20), 1);
    cyc();
    chk("flush_rdata_kept", inst_rdata_o, mdl_inst);
    chk("flush_no_done", 32'(stallreq_from_if), 1);
    data_dly = 0;
    wait_idle("flush_refetch", 40, n);
    chk("flush_refetch_rdata", inst_rdata_o, 32'h3C1A8000);
    inst_req_i = 1'b0; pipe_stall_i = 1'b0;
    cyc();
    chk("queue_drained", exp_q.size(), 0);

    // reset while in ADDR
    addr_dly = 10;
    exp_q.push_back('{1'b1, 1'b0, SZ_WORD, 32'h80003000, 32'h0, 32'h0});
    pipe_stall_i = 1'b1;
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC00040;
    data_req_i = 1'b1; data_wr_i = 1'b0; data_size_i = SZ_WORD; data_addr_i = 32'h80003000;
    n = 0;
    while (!bus_req_o && n < 10) begin cyc(); n++; end
    chk("rstmid_req_seen", 32'(n < 10), 1);
    rst = 1'b1;
    cyc();
    chk("rstmid_bus_req", 32'(bus_req_o), 0);
    chk("rstmid_bus_addr", bus_addr_o, 0);
    chk("rstmid_if_pending", 32'(stallreq_from_if), 1);
    chk("rstmid_mem_pending", 32'(stallreq_from_mem), 1);
    inst_req_i = 1'b0; data_req_i = 1'b0;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    addr_dly = 0;
    cyc();
    exp_q.push_back('{1'b0, 1'b0, SZ_WORD, 32'hBFC00000, 32'h0, 32'h01234567});
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC00000;
    wait_idle("post_rst", 40, n);
    chk("post_rst_latency", n, 3);
    chk("post_rst_rdata", inst_rdata_o, 32'h01234567);
    inst_req_i = 1'b0; pipe_stall_i = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
